// File: rtl/instruction_loader.sv
// Boot-time loader: parses a length-prefixed, checksummed byte stream into the
// instruction memory write port and holds the core in reset until the load verifies.
module instruction_loader #(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 9
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Start,
    input  logic [7:0]         i_Byte,
    input  logic               i_ByteValid,
    output logic               o_ByteReady,
    output logic [ADDR_W-1:0]  o_Addr,
    output logic [INSTR_W-1:0] o_WrData,
    output logic               o_WrEn,
    output logic               o_CoreReset,
    output logic               o_Busy,
    output logic               o_Done,
    output logic               o_Error
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CHECK, DONE, ERROR
    } state_t;

    state_t             state;
    logic [7:0]         len_lo;
    logic [7:0]         lo_byte;
    logic [7:0]         csum;
    logic [ADDR_W-1:0]  last_addr;
    logic [ADDR_W-1:0]  addr_cnt;

    logic               accept;
    logic [15:0]        len16;
    logic [15:0]        word16;
    logic               len_bad;
    logic               word_bad;
    logic [7:0]         csum_nx;

    // o_ByteReady is high exactly in the byte-consuming states, so it doubles as the state qualifier.
    assign accept   = i_ByteValid & o_ByteReady;
    assign len16    = {i_Byte, len_lo};
    assign word16   = {i_Byte, lo_byte};
    assign len_bad  = (len16 >> ADDR_W) != 16'd0;
    assign word_bad = (word16 >> INSTR_W) != 16'd0;
    assign csum_nx  = csum + i_Byte;

    // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= IDLE;
            len_lo      <= '0;
            lo_byte     <= '0;
            csum        <= '0;
            last_addr   <= '0;
            addr_cnt    <= '0;
            o_ByteReady <= 1'b0;
            o_Addr      <= '0;
            o_WrData    <= '0;
            o_WrEn      <= 1'b0;
            o_CoreReset <= 1'b1;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_Error     <= 1'b0;
        end else begin
            o_WrEn <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (i_Start) begin
                        state       <= LEN_LO;
                        addr_cnt    <= '0;
                        csum        <= '0;
                        o_Done      <= 1'b0;
                        o_Error     <= 1'b0;
                        o_CoreReset <= 1'b1;
                        o_Busy      <= 1'b1;
                        o_ByteReady <= 1'b1;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len_lo <= i_Byte;
                        csum   <= csum_nx;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        if (len_bad) begin
                            state       <= ERROR;
                            o_Error     <= 1'b1;
                            o_Busy      <= 1'b0;
                            o_ByteReady <= 1'b0;
                        end else begin
                            last_addr <= len16[ADDR_W-1:0];
                            csum      <= csum_nx;
                            state     <= DAT_LO;
                        end
                    end
                end
                DAT_LO: begin
                    if (accept) begin
                        lo_byte <= i_Byte;
                        csum    <= csum_nx;
                        state   <= DAT_HI;
                    end
                end
                DAT_HI: begin
                    if (accept) begin
                        if (word_bad) begin
                            state       <= ERROR;
                            o_Error     <= 1'b1;
                            o_Busy      <= 1'b0;
                            o_ByteReady <= 1'b0;
                        end else begin
                            o_WrEn   <= 1'b1;
                            o_Addr   <= addr_cnt;
                            o_WrData <= word16[INSTR_W-1:0];
                            csum     <= csum_nx;
                            // The counter stops at the last address rather than wrapping.
                            if (addr_cnt == last_addr) begin
                                state <= CHECK;
                            end else begin
                                addr_cnt <= addr_cnt + ADDR_W'(1);
                                state    <= DAT_LO;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        o_Busy      <= 1'b0;
                        o_ByteReady <= 1'b0;
                        if (csum_nx == 8'd0) begin
                            state       <= DONE;
                            o_Done      <= 1'b1;
                            o_CoreReset <= 1'b0;
                        end else begin
                            state   <= ERROR;
                            o_Error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized scoreboard bench for instruction_loader: a stream-level model predicts
// the write sequence and final verdict; a negedge monitor checks every write strobe.
module tb_instruction_loader;

    localparam int ADDR_W   = 9;
    localparam int INSTR_W  = 9;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int HI_LIMIT = 1 << (INSTR_W - 8);
    localparam int BUDGET   = 20000;

    typedef logic [7:0] stream_t[$];
    typedef struct { int addr; int data; } wr_t;

    logic               i_Clk = 1'b0;
    logic               i_Reset;
    logic               i_Start;
    logic [7:0]         i_Byte;
    logic               i_ByteValid;
    logic               o_ByteReady;
    logic [ADDR_W-1:0]  o_Addr;
    logic [INSTR_W-1:0] o_WrData;
    logic               o_WrEn;
    logic               o_CoreReset;
    logic               o_Busy;
    logic               o_Done;
    logic               o_Error;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    instruction_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_Start     (i_Start),
        .i_Byte      (i_Byte),
        .i_ByteValid (i_ByteValid),
        .o_ByteReady (o_ByteReady),
        .o_Addr      (o_Addr),
        .o_WrData    (o_WrData),
        .o_WrEn      (o_WrEn),
        .o_CoreReset (o_CoreReset),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_Error     (o_Error)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk the stream by its format rules, queue the writes, return the verdict.
    function automatic bit model(input stream_t s);
        int len, n, lo, hi, total;
        len = int'(s[0]) + 256 * int'(s[1]);
        if (len >= DEPTH) return 1'b0;
        n = len + 1;
        total = int'(s[0]) + int'(s[1]);
        for (int w = 0; w < n; w++) begin
            lo = int'(s[2 + 2 * w]);
            hi = int'(s[3 + 2 * w]);
            if (hi >= HI_LIMIT) return 1'b0;
            exp_q.push_back('{w, hi * 256 + lo});
            total += lo + hi;
        end
        total += int'(s[2 + 2 * n]);
        return (total % 256) == 0;
    endfunction

    // mode: 0 good, 1 bad check byte, 2 oversized high byte, 3 oversized length
    function automatic stream_t build(input int n, input int mode);
        stream_t s;
        int sum, d, lo, hi, bad_w, ck;
        sum = 0;
        s.push_back(8'((n - 1) & 255));
        s.push_back(8'((n - 1) >> 8));
        if (mode == 3) s[1] = 8'($urandom_range(255, 2));
        sum = int'(s[0]) + int'(s[1]);
        bad_w = int'($urandom_range(n - 1, 0));
        for (int w = 0; w < n; w++) begin
            d  = int'($urandom_range(DEPTH - 1, 0)) & ((1 << INSTR_W) - 1);
            lo = d & 255;
            hi = d >> 8;
            if (mode == 2 && w == bad_w) hi = int'($urandom_range(255, HI_LIMIT));
            s.push_back(8'(lo));
            s.push_back(8'(hi));
            sum += lo + hi;
        end
        ck = (256 - (sum % 256)) % 256;
        if (mode == 1) ck = (ck + int'($urandom_range(255, 1))) % 256;
        s.push_back(8'(ck));
        return s;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset"}, 32'(o_CoreReset), 1);
        check({tag, "_byte_ready"}, 32'(o_ByteReady), 0);
        check({tag, "_wr_en"},      32'(o_WrEn), 0);
        check({tag, "_addr"},       32'(o_Addr), 0);
        check({tag, "_wr_data"},    32'(o_WrData), 0);
        check({tag, "_busy"},       32'(o_Busy), 0);
        check({tag, "_done"},       32'(o_Done), 0);
        check({tag, "_error"},      32'(o_Error), 0);
    endtask

    task automatic start_load();
        @(negedge i_Clk) i_Start = 1'b1;
        @(negedge i_Clk) i_Start = 1'b0;
        check("start_busy",       32'(o_Busy), 1);
        check("start_ready",      32'(o_ByteReady), 1);
        check("start_core_reset", 32'(o_CoreReset), 1);
        check("start_done_clear", 32'(o_Done), 0);
        check("start_err_clear",  32'(o_Error), 0);
    endtask

    // Called at a negedge; stops early once the loader stops accepting bytes.
    task automatic drive(input stream_t s, input int gap_pct, input int max_bytes, input bit start_noise);
        int idx = 0;
        int cyc = 0;
        while (idx < s.size() && idx < max_bytes && cyc < BUDGET) begin
            if (!o_ByteReady) break;
            i_ByteValid = ($urandom_range(99, 0) >= gap_pct);
            i_Byte      = i_ByteValid ? s[idx] : 8'($urandom);
            i_Start     = start_noise && ($urandom_range(7, 0) == 0);
            if (i_ByteValid) idx++;
            cyc++;
            @(negedge i_Clk);
        end
        i_ByteValid = 1'b0;
        i_Start     = 1'b0;
        check("drive_in_budget", 32'(cyc < BUDGET), 1);
    endtask

    task automatic finish_status(input bit ok, input string tag);
        repeat (2) @(negedge i_Clk);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        check({tag, "_done"},       32'(o_Done), 32'(ok));
        check({tag, "_error"},      32'(o_Error), 32'(!ok));
        check({tag, "_core_reset"}, 32'(o_CoreReset), 32'(!ok));
        check({tag, "_busy"},       32'(o_Busy), 0);
        check({tag, "_ready"},      32'(o_ByteReady), 0);
        exp_q.delete();
    endtask

    task automatic run(input stream_t s, input int gap_pct, input bit noise, input string tag);
        bit ok;
        ok = model(s);
        start_load();
        drive(s, gap_pct, s.size(), noise);
        finish_status(ok, tag);
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge i_Clk) begin
        wr_t e;
        check("done_error_exclusive", 32'(o_Done & o_Error), 0);
        if (o_WrEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(o_WrEn), 0);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(o_Addr), e.addr);
                check("write_data", 32'(o_WrData), e.data);
            end
        end
    end

    initial begin
        stream_t s;
        i_Reset     = 1'b0;
        i_Start     = 1'b0;
        i_Byte      = 8'h00;
        i_ByteValid = 1'b0;

        #2 i_Reset = 1'b1;
        #1 check_reset_values("por");
        repeat (2) @(negedge i_Clk);
        i_Reset = 1'b0;

        s = '{8'h02, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h01, 8'hAA, 8'h00, 8'h53};
        run(s, 0, 1'b0, "nominal");
        s[8] = 8'h54;
        run(s, 0, 1'b0, "bad_check");

        s = '{8'h00, 8'h00, 8'h05, 8'h02};
        run(s, 0, 1'b0, "width_err");
        run(build(5, 0), 0, 1'b0, "after_err");

        run(build(DEPTH, 0), 30, 1'b0, "max_len");
        check("max_last_addr", 32'(o_Addr), DEPTH - 1);
        s = '{8'hFF, 8'h02, 8'h00, 8'h00};
        run(s, 0, 1'b0, "len_err");

        for (int i = 0; i < 10; i++) begin
            run(build(int'($urandom_range(24, 1)), int'($urandom_range(3, 0))),
                int'($urandom_range(50, 0)), 1'b1, "random");
        end

        // Reset after three words of a ten-word load.
        s = build(10, 0);
        for (int w = 0; w < 3; w++)
            exp_q.push_back('{w, int'(s[3 + 2 * w]) * 256 + int'(s[2 + 2 * w])});
        start_load();
        drive(s, 0, 8, 1'b0);
        #2 i_Reset = 1'b1;
        #1 check_reset_values("mid_reset");
        check("mid_reset_writes_seen", exp_q.size(), 0);
        @(negedge i_Clk) i_Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            i_ByteValid = 1'b1;
            i_Byte      = 8'($urandom);
            @(negedge i_Clk);
            check("idle_core_reset", 32'(o_CoreReset), 1);
            check("idle_ready",      32'(o_ByteReady), 0);
        end
        i_ByteValid = 1'b0;

        run(build(4, 0), 10, 1'b0, "reload");
        run(build(3, 0), 0, 1'b0, "restart_from_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time program loader that writes the 512×9 instruction memory of the microcontroller from a byte stream. It is the writer side of the instruction-memory interface the core only reads. It holds the core in reset while loading, validates the stream with a length header and an 8-bit checksum, and releases the core only after a verified load. It sits beside the core and instruction memory at the microcontroller top level, between an external byte source (UART receiver or test host) and the instruction memory write port.

## Interface
- ADDR_W, 9: instruction address width; depth = 2^ADDR_W words.
- INSTR_W, 9: instruction width; must satisfy 9 ≤ INSTR_W ≤ 16. Each word is sent as two bytes.
- i_Clk  in  1  single clock; all state changes occur on its rising edge.
- i_Reset  in  1  reset, asynchronous and active-high.
- i_Start  in  1  one-cycle request to begin a load.
- i_Byte  in  8  stream byte.
- i_ByteValid  in  1  i_Byte is valid this cycle.
- o_ByteReady  out  1  loader accepts a byte this cycle; transfer occurs when i_ByteValid & o_ByteReady.
- o_Addr  out  ADDR_W  instruction memory write address.
- o_WrData  out  INSTR_W  instruction memory write data.
- o_WrEn  out  1  one-cycle write strobe.
- o_CoreReset  out  1  holds the core in reset when high.
- o_Busy  out  1  load in progress.
- o_Done  out  1  last load completed and verified.
- o_Error  out  1  last load aborted.

## Operation
- Stream format, in order:
  - LEN_LO, LEN_HI: 16-bit value N−1, low byte first.
  - N word pairs: low byte = bits [7:0]; high byte = bits [INSTR_W−1:8].
  - One check byte.
- States: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + i_Start → LEN_LO. This clears the address counter, checksum, o_Done and o_Error, and sets o_CoreReset. i_Start in any other state is ignored.
- LEN_LO → LEN_HI → DAT_LO on byte acceptance. In LEN_HI, any set bit above ADDR_W−1 of the 16-bit length → ERROR.
- DAT_LO → DAT_HI on acceptance; the low byte is latched.
- DAT_HI on acceptance:
  - Any set bit above INSTR_W−1 → ERROR, and that word is not written.
  - Otherwise, write {high, low} to the address counter.
  - If the counter equals N−1 → CHECK; else increment the counter and go to DAT_LO.
- Checksum: 8-bit mod-256 sum of every accepted byte from LEN_LO through the last DAT_HI. The check byte must make the total, including itself, equal 0x00.
  - Match → DONE.
  - Mismatch → ERROR.
- DONE: o_Done=1, o_CoreReset=0.
- ERROR: o_Error=1, o_CoreReset=1. Words already written stay written. Exit is only via i_Start or i_Reset.
- o_ByteReady=1 exactly in LEN_LO, LEN_HI, DAT_LO, DAT_HI, CHECK. One byte per clock is sustained. Gaps in i_ByteValid of any length are allowed.
- The address counter never wraps; the maximum N = 2^ADDR_W ends at address 2^ADDR_W−1.

## Timing
- Reset values (asynchronous): state IDLE, o_CoreReset=1, o_ByteReady=0, o_WrEn=0, o_Addr=0, o_WrData=0, o_Busy=0, o_Done=0, o_Error=0.
- i_Reset mid-load returns to IDLE immediately. The core stays held in reset and no further writes occur.
- i_Start sampled at edge t → o_Busy=1, o_ByteReady=1, o_CoreReset=1 from t+1.
- DAT_HI byte accepted at edge t → o_WrEn=1 with stable o_Addr/o_WrData during cycle t..t+1. All three are registered outputs. o_WrEn is 0 otherwise.
- CHECK byte accepted at edge t → from t+1: DONE (o_Done=1, o_CoreReset=0) or ERROR (o_Error=1). o_Busy=0 and o_ByteReady=0 in both cases.
- A length or high-byte violation accepted at edge t → ERROR from t+1.
- o_Busy = state ∉ {IDLE, DONE, ERROR}. o_Done and o_Error are never high together.

## Test plan
- Reset: assert i_Reset asynchronously mid-cycle → all outputs at their reset values immediately, o_CoreReset=1.
- Nominal load: i_Start, then bytes 02 00 01 00 FF 01 AA 00 53, back-to-back → writes 0x001@0, 0x1FF@1, 0x0AA@2, each o_WrEn one cycle after its high byte. Then o_Done=1 and o_CoreReset=0.
- Bad checksum: same stream with check byte 54 → all three writes occur, then o_Error=1, o_CoreReset=1, o_Done=0.
- Width violation: 00 00 05 02 → ERROR on the 02 byte, no o_WrEn pulse at any point. Then a new i_Start followed by a valid stream → DONE.
- Max length with gaps: length bytes FF 01, 512 words with random i_ByteValid gaps → last write at 0x1FF with no wrap. Correct check byte → DONE. A length high byte of 02 → ERROR.
- Reset mid-load: i_Reset after 3 words of a 10-word load → IDLE, no further writes, o_CoreReset stays 1. A subsequent i_Start during DONE reasserts o_CoreReset next cycle.
